// File: rtl/image_stream_reader.sv
// -----------------------------------------------------------------------------
// image_stream_reader
//
// Captures a 32x32 one-bit image on a start request and streams it out one
// pixel per accepted transfer, in raster order (row-major, index 0..1023).
// While streaming, it accumulates the count of set pixels and the bounding
// box that contains them. With INVERT=1, every streamed pixel is inverted and
// the statistics are computed on the inverted value.
//
// Ports
//   clk        : single clock; all state changes happen on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle capture request; honoured only when idle
//   in_image   : 1024-bit bitmap; pixel (r,c) = in_image[r*32+c]
//   busy       : high while streaming and during the done cycle
//   pix_valid  : a streamed pixel is being offered
//   pix_ready  : downstream accepts the offered pixel
//   pix_data   : pixel value (after optional inversion)
//   pix_row    : row of the offered pixel
//   pix_col    : column of the offered pixel
//   pix_last   : the offered pixel is index 1023
//   done       : one-cycle pulse in the cycle after the final transfer
//   ones_count : number of set pixels seen so far (0..1024)
//   min_row, max_row, min_col, max_col : bounding box of the set pixels
//   empty      : no set pixel in the image (bounds read 0 in that case)
//   state_dbg  : current FSM state (0=IDLE, 1=STREAM, 2=DONE)
//
// Handshake: a transfer happens on a rising edge where pix_valid and
// pix_ready are both 1. pix_valid never drops while a pixel is pending, and
// the offered pixel (data, row, col, last) is held stable until accepted.
// -----------------------------------------------------------------------------
module image_stream_reader #(
   parameter bit INVERT = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1023:0] in_image,
   output logic          busy,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic          pix_data,
   output logic [4:0]    pix_row,
   output logic [4:0]    pix_col,
   output logic          pix_last,
   output logic          done,
   output logic [10:0]   ones_count,
   output logic [4:0]    min_row,
   output logic [4:0]    max_row,
   output logic [4:0]    min_col,
   output logic [4:0]    max_col,
   output logic          empty,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [9:0] LAST_IDX = 10'd1023;

   state_t         state_q;
   state_t         state_d;

   logic [1023:0]  shadow_q;
   logic [9:0]     idx_q;
   logic [10:0]    ones_q;
   logic [4:0]     min_row_q;
   logic [4:0]     max_row_q;
   logic [4:0]     min_col_q;
   logic [4:0]     max_col_q;

   logic           capture;
   logic           xfer;
   logic           cur_pix;
   logic           at_last;
   logic [4:0]     cur_row;
   logic [4:0]     cur_col;

   // Start is only honoured in IDLE; during STREAM/DONE it is ignored.
   assign capture = (state_q == ST_IDLE) && start;
   assign xfer    = (state_q == ST_STREAM) && pix_ready;
   assign cur_pix = shadow_q[idx_q] ^ INVERT;
   assign at_last = (idx_q == LAST_IDX);
   assign cur_row = idx_q[9:5];
   assign cur_col = idx_q[4:0];

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // The final transfer ends the image; there is no second pass.
            if (xfer && at_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // Pixel outputs are forced to zero outside STREAM so that reset and idle
   // present a clean, all-zero pixel port regardless of INVERT.
   // --------------------------------------------------------------------------
   always_comb begin
      busy      = 1'b0;
      pix_valid = 1'b0;
      pix_data  = 1'b0;
      pix_row   = 5'd0;
      pix_col   = 5'd0;
      pix_last  = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_STREAM: begin
            busy      = 1'b1;
            pix_valid = 1'b1;
            pix_data  = cur_pix;
            pix_row   = cur_row;
            pix_col   = cur_col;
            pix_last  = at_last;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign state_dbg = state_q;

   // --------------------------------------------------------------------------
   // Shadow image: loaded once on capture so later changes on in_image
   // cannot disturb the stream in progress.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (capture) begin
         shadow_q <= in_image;
      end
   end

   // --------------------------------------------------------------------------
   // Pixel index: parks on 1023 after the last transfer rather than wrapping.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 10'd0;
      end else if (capture) begin
         idx_q <= 10'd0;
      end else if (xfer && !at_last) begin
         idx_q <= idx_q + 10'd1;
      end
   end

   // --------------------------------------------------------------------------
   // Statistics: cleared on capture, updated on each transfer of a set pixel.
   // The first set pixel (count still zero) seeds all four bounds so the box
   // never has to start from an artificial extreme.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q    <= 11'd0;
         min_row_q <= 5'd0;
         max_row_q <= 5'd0;
         min_col_q <= 5'd0;
         max_col_q <= 5'd0;
      end else if (capture) begin
         ones_q    <= 11'd0;
         min_row_q <= 5'd0;
         max_row_q <= 5'd0;
         min_col_q <= 5'd0;
         max_col_q <= 5'd0;
      end else if (xfer && cur_pix) begin
         ones_q <= ones_q + 11'd1;
         if (ones_q == 11'd0) begin
            min_row_q <= cur_row;
            max_row_q <= cur_row;
            min_col_q <= cur_col;
            max_col_q <= cur_col;
         end else begin
            if (cur_row < min_row_q) begin
               min_row_q <= cur_row;
            end
            if (cur_row > max_row_q) begin
               max_row_q <= cur_row;
            end
            if (cur_col < min_col_q) begin
               min_col_q <= cur_col;
            end
            if (cur_col > max_col_q) begin
               max_col_q <= cur_col;
            end
         end
      end
   end

   assign ones_count = ones_q;
   assign min_row    = min_row_q;
   assign max_row    = max_row_q;
   assign min_col    = min_col_q;
   assign max_col    = max_col_q;
   assign empty      = (ones_q == 11'd0);

endmodule

// File: tb/tb_image_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_image_stream_reader
//
// Directed bench for image_stream_reader. Two instances share all inputs:
// dut (INVERT=0) whose pixel stream is scoreboarded, and dut_inv (INVERT=1)
// whose statistics are checked against the inverted image.
// -----------------------------------------------------------------------------
module tb_image_stream_reader;

   // --------------------------------------------------------------------------
   // Clock / reset
   // --------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pix_ready = 1'b0;
   logic [1023:0] in_image = '0;

   always #5 clk = ~clk;

   // dut outputs
   logic        busy, pix_valid, pix_data, pix_last, done, empty;
   logic [4:0]  pix_row, pix_col, min_row, max_row, min_col, max_col;
   logic [10:0] ones_count;
   logic [1:0]  state_dbg;

   // dut_inv outputs
   logic        i_busy, i_pix_valid, i_pix_data, i_pix_last, i_done, i_empty;
   logic [4:0]  i_pix_row, i_pix_col, i_min_row, i_max_row, i_min_col, i_max_col;
   logic [10:0] i_ones_count;
   logic [1:0]  i_state_dbg;

   image_stream_reader #(.INVERT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_image(in_image),
      .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
      .pix_last(pix_last), .done(done), .ones_count(ones_count),
      .min_row(min_row), .max_row(max_row), .min_col(min_col),
      .max_col(max_col), .empty(empty), .state_dbg(state_dbg)
   );

   image_stream_reader #(.INVERT(1'b1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .start(start), .in_image(in_image),
      .busy(i_busy), .pix_valid(i_pix_valid), .pix_ready(pix_ready),
      .pix_data(i_pix_data), .pix_row(i_pix_row), .pix_col(i_pix_col),
      .pix_last(i_pix_last), .done(i_done), .ones_count(i_ones_count),
      .min_row(i_min_row), .max_row(i_max_row), .min_col(i_min_col),
      .max_col(i_max_col), .empty(i_empty), .state_dbg(i_state_dbg)
   );

   // --------------------------------------------------------------------------
   // Scoreboard state
   // --------------------------------------------------------------------------
   int         checks = 0;
   int         errors = 0;
   logic [0:0] exp_q[$];
   int         xfers;
   int         done_cyc;
   bit         aborted;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference statistics computed directly from an image.
   function automatic void model_stats(input logic [1023:0] im, output int cnt,
                                       output int mnr, output int mxr,
                                       output int mnc, output int mxc);
      int r, c;
      cnt = 0; mnr = 0; mxr = 0; mnc = 0; mxc = 0;
      for (int i = 0; i < 1024; i++) begin
         if (im[i]) begin
            r = i / 32;
            c = i % 32;
            if (cnt == 0) begin
               mnr = r; mxr = r; mnc = c; mxc = c;
            end else begin
               if (r < mnr) mnr = r;
               if (r > mxr) mxr = r;
               if (c < mnc) mnc = c;
               if (c > mxc) mxc = c;
            end
            cnt++;
         end
      end
   endfunction

   // Sparse random image confined to a window, so bounds are non-trivial.
   function automatic logic [1023:0] rand_image(input int r0, input int r1,
                                                input int c0, input int c1);
      logic [1023:0] im;
      im = '0;
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++)
            if ($urandom_range(0, 7) == 0) im[r*32+c] = 1'b1;
      return im;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ctrl"},   32'({busy, pix_valid, pix_data, pix_last, done}), 32'd0);
      check({tag, "_coord"},  32'({pix_row, pix_col}), 32'd0);
      check({tag, "_ones"},   32'(ones_count), 32'd0);
      check({tag, "_bounds"}, 32'({min_row, max_row, min_col, max_col}), 32'd0);
      check({tag, "_empty"},  32'(empty), 32'd1);
      check({tag, "_state"},  32'(state_dbg), 32'd0);
      check({tag, "_inv_ctrl"},
            32'({i_busy, i_pix_valid, i_pix_data, i_pix_last, i_done, i_empty, i_state_dbg}),
            32'h04);
      check({tag, "_inv_data"}, 32'({i_pix_row, i_pix_col, i_ones_count}), 32'd0);
      check({tag, "_inv_bounds"}, 32'({i_min_row, i_max_row, i_min_col, i_max_col}), 32'd0);
   endtask

   task automatic check_stats(input string tag, input bit use_inv, input int e_cnt,
                              input int e_mnr, input int e_mxr, input int e_mnc, input int e_mxc);
      logic [10:0] oc;
      logic [4:0]  omnr, omxr, omnc, omxc;
      logic        oe;
      oc   = use_inv ? i_ones_count : ones_count;
      omnr = use_inv ? i_min_row : min_row;
      omxr = use_inv ? i_max_row : max_row;
      omnc = use_inv ? i_min_col : min_col;
      omxc = use_inv ? i_max_col : max_col;
      oe   = use_inv ? i_empty : empty;
      check({tag, "_ones"},    32'(oc), e_cnt);
      check({tag, "_min_row"}, 32'(omnr), e_mnr);
      check({tag, "_max_row"}, 32'(omxr), e_mxr);
      check({tag, "_min_col"}, 32'(omnc), e_mnc);
      check({tag, "_max_col"}, 32'(omxc), e_mxc);
      check({tag, "_empty"},   32'(oe), (e_cnt == 0) ? 32'd1 : 32'd0);
   endtask

   // --------------------------------------------------------------------------
   // Driver: pulses start, then drives pix_ready and scoreboards every offered
   // pixel. restart_at / reset_at (-1 = unused) inject a second start or a
   // reset once the given number of transfers has happened. Returns in the
   // IDLE cycle right after DONE (or after reset release).
   // --------------------------------------------------------------------------
   task automatic run_stream(input string tag, input logic [1023:0] image,
                             input bit rand_ready, input int restart_at, input int reset_at);
      int          cyc;
      bit          seen_done, stalled, restarted;
      logic [11:0] held, cur;
      int          bad_data, bad_coord, bad_stall, bad_ctrl;
      exp_q.delete();
      for (int i = 0; i < 1024; i++) exp_q.push_back(image[i]);
      in_image  = image;
      start     = 1'b1;
      pix_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      xfers = 0; done_cyc = 0; cyc = 1; aborted = 0;
      seen_done = 0; stalled = 0; restarted = 0; held = '0;
      bad_data = 0; bad_coord = 0; bad_stall = 0; bad_ctrl = 0;
      while (!seen_done && cyc < 4000) begin
         if (xfers == reset_at) begin
            rst_n = 1'b0; #1;
            check_reset_vals({tag, "_abort"});
            @(posedge clk); #1;
            check_reset_vals({tag, "_abort_hold"});
            rst_n   = 1'b1;
            aborted = 1;
            break;
         end
         if (xfers == restart_at && !restarted) begin
            start     = 1'b1;
            in_image  = ~image;
            restarted = 1;
         end else begin
            start = 1'b0;
         end
         pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         cur = {pix_data, pix_row, pix_col, pix_last};
         if (pix_valid === 1'b1) begin
            if (stalled && cur !== held) bad_stall++;
            if (exp_q.size() == 0 || pix_data !== exp_q[0]) bad_data++;
            if (pix_row !== xfers[9:5] || pix_col !== xfers[4:0] || pix_last !== (xfers == 1023))
               bad_coord++;
            if (busy !== 1'b1 || done !== 1'b0) bad_ctrl++;
            if (pix_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               xfers++;
               stalled = 0;
            end else begin
               stalled = 1;
               held    = cur;
            end
         end else if (done === 1'b1) begin
            seen_done = 1;
            done_cyc  = cyc;
            if (busy !== 1'b1) bad_ctrl++;
         end else begin
            bad_ctrl++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_xfers"}, xfers, aborted ? reset_at : 1024);
      check({tag, "_data"}, bad_data, 0);
      check({tag, "_coord"}, bad_coord, 0);
      check({tag, "_stall"}, bad_stall, 0);
      check({tag, "_ctrl"}, bad_ctrl, 0);
      if (!aborted) begin
         check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
         check({tag, "_after_done"}, 32'({done, busy, pix_valid}), 32'd0);
      end
   endtask

   // --------------------------------------------------------------------------
   // Directed sequence
   // --------------------------------------------------------------------------
   initial begin
      logic [1023:0] img;
      int cnt, mnr, mxr, mnc, mxc;
      int bad;

      // Reset values
      rst_n    = 1'b0;
      in_image = '1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_no_valid", 32'({busy, pix_valid, done}), 32'd0);

      // All-zero image, ready held high
      run_stream("zero", '0, 1'b0, -1, -1);
      check("zero_done_cyc", done_cyc, 1025);
      check_stats("zero", 1'b0, 0, 0, 0, 0, 0);
      check_stats("zero_inv", 1'b1, 1024, 0, 31, 0, 31);

      // All-ones image, started in the IDLE cycle right after DONE
      run_stream("ones", '1, 1'b0, -1, -1);
      check("ones_done_cyc", done_cyc, 1025);
      check_stats("ones", 1'b0, 1024, 0, 31, 0, 31);
      check_stats("ones_inv", 1'b1, 0, 0, 0, 0, 0);

      // Single set pixel at index 167 = row 5, col 7
      img = '0;
      img[167] = 1'b1;
      run_stream("bit167", img, 1'b1, -1, -1);
      check_stats("bit167", 1'b0, 1, 5, 5, 7, 7);
      check_stats("bit167_inv", 1'b1, 1023, 0, 31, 0, 31);

      // Random image, random backpressure
      img = rand_image(3, 20, 6, 27);
      run_stream("rand", img, 1'b1, -1, -1);
      model_stats(img, cnt, mnr, mxr, mnc, mxc);
      check_stats("rand", 1'b0, cnt, mnr, mxr, mnc, mxc);
      model_stats(~img, cnt, mnr, mxr, mnc, mxc);
      check_stats("rand_inv", 1'b1, cnt, mnr, mxr, mnc, mxc);

      // Statistics hold while idle even if in_image moves
      in_image = '1;
      repeat (3) @(posedge clk);
      #1;
      model_stats(img, cnt, mnr, mxr, mnc, mxc);
      check_stats("rand_hold", 1'b0, cnt, mnr, mxr, mnc, mxc);

      // Second start mid-stream plus in_image change: both ignored
      img = rand_image(10, 28, 1, 14);
      run_stream("restart", img, 1'b1, 300, -1);
      model_stats(img, cnt, mnr, mxr, mnc, mxc);
      check_stats("restart", 1'b0, cnt, mnr, mxr, mnc, mxc);

      // Reset at transfer 500 aborts the stream
      img = rand_image(0, 31, 0, 31);
      run_stream("abort", img, 1'b1, -1, 500);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("abort_idle", bad, 0);
      check("abort_stats_clear", 32'(ones_count), 32'd0);
      @(posedge clk); #1;

      // Fresh stream after the abort starts from index 0 with clean stats
      img = rand_image(16, 24, 20, 30);
      run_stream("fresh", img, 1'b0, -1, -1);
      check("fresh_done_cyc", done_cyc, 1025);
      model_stats(img, cnt, mnr, mxr, mnc, mxc);
      check_stats("fresh", 1'b0, cnt, mnr, mxr, mnc, mxc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
